// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encodings and the default debounce length.
// Used by the controller, the time counter and the display stages.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } sw_state_t;

    localparam int DEFAULT_DB_LEN = 2;

endpackage

// File: rtl/stopwatch_ctrl_btn_conditioner.sv
// One push-button conditioner: 2-flop synchronizer, DB_LEN-sample debounce, and a
// registered single-cycle pulse on the rising edge of the debounced level.
module btn_conditioner
    import stopwatch_pkg::*;
#(
    parameter int DB_LEN = DEFAULT_DB_LEN
) (
    input  logic counter_clk,
    input  logic reset,
    input  logic btn,
    output logic p
);

    logic              sync1;
    logic              sync2;
    logic [DB_LEN-1:0] shift;
    logic              db;

    // shift[0] holds the newest synchronized sample; db only moves on a unanimous window.
    always_ff @(posedge counter_clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            shift <= '0;
            db    <= 1'b0;
            p     <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            shift <= {shift[DB_LEN-2:0], sync2};
            if (&shift) begin
                db <= 1'b1;
            end else if (~|shift) begin
                db <= 1'b0;
            end
            p <= (&shift) && !db;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: conditions the three buttons and runs the
// IDLE/RUN/PAUSE/DONE machine driving the counter enable/clear and display freeze.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_LEN = DEFAULT_DB_LEN
) (
    input  logic       counter_clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       lap_btn,
    input  logic       clear_btn,
    input  logic       at_max,
    output logic       count_en,
    output logic       count_clr,
    output logic       freeze,
    output logic [1:0] state
);

    logic start_p;
    logic lap_p;
    logic clear_p;

    sw_state_t state_q;
    sw_state_t state_d;
    logic      freeze_q;
    logic      freeze_d;
    logic      clr_q;
    logic      clr_d;

    btn_conditioner #(.DB_LEN(DB_LEN)) u_start (
        .counter_clk (counter_clk),
        .reset       (reset),
        .btn         (start_btn),
        .p           (start_p)
    );

    btn_conditioner #(.DB_LEN(DB_LEN)) u_lap (
        .counter_clk (counter_clk),
        .reset       (reset),
        .btn         (lap_btn),
        .p           (lap_p)
    );

    btn_conditioner #(.DB_LEN(DB_LEN)) u_clear (
        .counter_clk (counter_clk),
        .reset       (reset),
        .btn         (clear_btn),
        .p           (clear_p)
    );

    always_ff @(posedge counter_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            freeze_q <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            freeze_q <= freeze_d;
            clr_q    <= clr_d;
        end
    end

    // Event priority: clear > at_max > start > lap; lower-priority events in the same cycle are dropped.
    always_comb begin
        state_d  = state_q;
        freeze_d = freeze_q;
        clr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_p) begin
                    clr_d    = 1'b1;
                    freeze_d = 1'b0;
                end else if (start_p) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clear_p) begin
                    state_d  = IDLE;
                    clr_d    = 1'b1;
                    freeze_d = 1'b0;
                end else if (at_max) begin
                    state_d  = DONE;
                    freeze_d = 1'b0;
                end else if (start_p) begin
                    state_d = PAUSE;
                end else if (lap_p) begin
                    freeze_d = !freeze_q;
                end
            end
            PAUSE: begin
                if (clear_p) begin
                    state_d  = IDLE;
                    clr_d    = 1'b1;
                    freeze_d = 1'b0;
                end else if (start_p) begin
                    state_d = RUN;
                end else if (lap_p) begin
                    freeze_d = 1'b0;
                end
            end
            DONE: begin
                if (clear_p) begin
                    state_d  = IDLE;
                    clr_d    = 1'b1;
                    freeze_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                freeze_d = 1'b0;
            end
        endcase
    end

    assign count_en  = (state_q == RUN);
    assign count_clr = clr_q;
    assign freeze    = freeze_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized scoreboard bench for stopwatch_ctrl against a sample-window reference model.
// The driver pushes expected outputs per clock; a monitor pops and compares after each edge.
module tb_stopwatch_ctrl;

    localparam int DB = 2;
    localparam int HL = DB + 3;

    logic       counter_clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       lap_btn;
    logic       clear_btn;
    logic       at_max;
    logic       count_en;
    logic       count_clr;
    logic       freeze;
    logic [1:0] state;

    stopwatch_ctrl #(.DB_LEN(DB)) dut (
        .counter_clk (counter_clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .lap_btn     (lap_btn),
        .clear_btn   (clear_btn),
        .at_max      (at_max),
        .count_en    (count_en),
        .count_clr   (count_clr),
        .freeze      (freeze),
        .state       (state)
    );

    always #5 counter_clk = ~counter_clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [4:0] exp_q[$];
    bit         mon_en   = 0;

    // reference model: per-button sample history, debounced level, pulse, FSM
    int m_state;
    bit m_frz;
    bit m_clr;
    bit hist[3][HL];
    bit m_db[3];
    bit m_p[3];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0;
        m_frz   = 0;
        m_clr   = 0;
        for (int b = 0; b < 3; b++) begin
            m_db[b] = 0;
            m_p[b]  = 0;
            for (int i = 0; i < HL; i++) hist[b][i] = 0;
        end
    endfunction

    // Predicts the outputs right after the coming clock edge, given inputs held across it.
    function automatic void model_step(input bit s, input bit l, input bit c, input bit m);
        bit       sp;
        bit       lp;
        bit       cp;
        bit [2:0] ins;
        bit       all1;
        bit       all0;
        sp = m_p[0];
        lp = m_p[1];
        cp = m_p[2];
        m_clr = 0;
        case (m_state)
            0: if (cp) m_clr = 1; else if (sp) m_state = 1;
            1: begin
                if (cp) begin m_state = 0; m_clr = 1; m_frz = 0; end
                else if (m) begin m_state = 3; m_frz = 0; end
                else if (sp) m_state = 2;
                else if (lp) m_frz = !m_frz;
            end
            2: begin
                if (cp) begin m_state = 0; m_clr = 1; m_frz = 0; end
                else if (sp) m_state = 1;
                else if (lp) m_frz = 0;
            end
            default: if (cp) begin m_state = 0; m_clr = 1; m_frz = 0; end
        endcase
        // a pulse appears once the samples taken 3..DB+2 edges ago are all high
        ins = {c, l, s};
        for (int b = 0; b < 3; b++) begin
            for (int i = HL - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = ins[b];
            all1 = 1;
            all0 = 1;
            for (int i = 3; i < 3 + DB; i++) begin
                all1 = all1 & hist[b][i];
                all0 = all0 & !hist[b][i];
            end
            m_p[b] = all1 && !m_db[b];
            if (all1) m_db[b] = 1;
            else if (all0) m_db[b] = 0;
        end
        exp_q.push_back({m_state[1:0], (m_state == 1) ? 1'b1 : 1'b0, m_clr, m_frz});
    endfunction

    always @(posedge counter_clk) begin
        logic [4:0] e;
        #1;
        if (mon_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: no expected entry at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({state, count_en, count_clr, freeze} !== e) begin
                    n_fail++;
                    $display("FAIL outputs: got state=%b en=%b clr=%b frz=%b, expected state=%b en=%b clr=%b frz=%b (t=%0t)",
                             state, count_en, count_clr, freeze, e[4:3], e[2], e[1], e[0], $time);
                end
            end
        end
    end

    // Called at a falling edge: drive inputs, predict the next edge, wait one period.
    task automatic cycle(input bit s, input bit l, input bit c, input bit m);
        start_btn = s;
        lap_btn   = l;
        clear_btn = c;
        at_max    = m;
        model_step(s, l, c, m);
        @(negedge counter_clk);
    endtask

    task automatic hold(input bit s, input bit l, input bit c, input int n);
        repeat (n) cycle(s, l, c, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        reset     = 1'b1;
        start_btn = 1'b0;
        lap_btn   = 1'b0;
        clear_btn = 1'b0;
        at_max    = 1'b0;
        #1;
        check_val("async_reset_outputs", 32'({state, count_en, count_clr, freeze}), 0);
        mon_en = 0;
        exp_q.delete();
        @(negedge counter_clk);
        @(negedge counter_clk);
        model_reset();
        reset  = 1'b0;
        mon_en = 1;
    endtask

    int rem[3];
    bit lvl[3];
    int pct[3];

    initial begin
        reset     = 1'b1;
        start_btn = 1'b0;
        lap_btn   = 1'b0;
        clear_btn = 1'b0;
        at_max    = 1'b0;
        model_reset();
        repeat (2) @(negedge counter_clk);
        check_val("reset_outputs", 32'({state, count_en, count_clr, freeze}), 0);
        reset  = 1'b0;
        mon_en = 1;

        // single-cycle glitch is filtered
        cycle(1, 0, 0, 0);
        hold(0, 0, 0, 10);
        check_val("short_press_state", 32'({state, count_en}), 0);

        // held start: RUN exactly after edge 6, then no further transition
        hold(1, 0, 0, 5);
        check_val("start_edge5_state", 32'(state), 0);
        hold(1, 0, 0, 1);
        check_val("start_edge6_run", 32'({state, count_en}), 3'b011);
        hold(1, 0, 0, 44);
        check_val("start_held_run", 32'(state), 1);
        hold(0, 0, 0, 6);

        // lap toggles freeze while counting continues
        hold(0, 1, 0, 6);
        check_val("lap1_freeze_on", 32'({freeze, count_en}), 2'b11);
        hold(0, 0, 0, 6);
        hold(0, 1, 0, 6);
        check_val("lap2_freeze_off", 32'({freeze, count_en}), 2'b01);
        hold(0, 0, 0, 6);

        // at_max with freeze set: DONE, freeze forced off, start ignored, clear to IDLE
        hold(0, 1, 0, 6);
        hold(0, 0, 0, 6);
        check_val("pre_max_freeze", 32'(freeze), 1);
        cycle(0, 0, 0, 1);
        check_val("at_max_done", 32'({state, count_en, freeze}), 4'b1100);
        hold(1, 0, 0, 6);
        hold(0, 0, 0, 6);
        check_val("done_ignores_start", 32'(state), 3);
        hold(0, 0, 1, 6);
        check_val("done_clear_pulse", 32'({state, count_clr}), 3'b001);
        hold(0, 0, 1, 1);
        check_val("clear_pulse_one_cycle", 32'(count_clr), 0);
        hold(0, 0, 0, 6);

        // start+clear together in PAUSE: clear wins
        hold(1, 0, 0, 6);
        hold(0, 0, 0, 6);
        check_val("restart_run", 32'(state), 1);
        hold(1, 0, 0, 6);
        hold(0, 0, 0, 6);
        check_val("pause_state", 32'({state, count_en}), 3'b100);
        hold(1, 0, 1, 6);
        check_val("pause_start_clear", 32'({state, count_clr}), 3'b001);
        hold(1, 0, 1, 10);
        check_val("no_run_after_clear", 32'({state, count_en}), 0);
        hold(0, 0, 0, 6);

        // asynchronous reset mid-RUN with freeze set
        hold(1, 0, 0, 6);
        hold(0, 0, 0, 6);
        hold(0, 1, 0, 6);
        hold(0, 0, 0, 6);
        check_val("pre_reset_run_freeze", 32'({state, count_en, freeze}), 4'b0111);
        async_reset();

        // randomized button activity with rare at_max
        pct[0] = 45;
        pct[1] = 40;
        pct[2] = 12;
        for (int b = 0; b < 3; b++) begin
            rem[b] = 0;
            lvl[b] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    lvl[b] = ($urandom_range(0, 99) < pct[b]);
                    rem[b] = $urandom_range(1, 8);
                end
                rem[b]--;
            end
            if (n == 1500) async_reset();
            cycle(lvl[0], lvl[1], lvl[2], ($urandom_range(0, 29) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control front-end for the stopwatch, sitting directly upstream of the time counter. It conditions the raw start, lap and clear push-buttons and runs the run/pause/done state machine. It drives the counter's enable and clear, plus a display-freeze (lap) flag for the display stage. Everything runs on the slow counting clock, so counter and controller share one clock domain.

## Interface
Parameters:
- DB_LEN, 2, number of consecutive identical synchronized samples required to change a debounced level (≥ 2)

Ports:
- counter_clk  in  1  counting clock (one tick per tenth of a second)
- reset  in  1  asynchronous, active-high; clock counter_clk
- start_btn  in  1  raw start/stop button, asynchronous to counter_clk
- lap_btn  in  1  raw lap button, asynchronous
- clear_btn  in  1  raw clear button, asynchronous
- at_max  in  1  from time counter: high while count equals 9:59.9
- count_en  out  1  counter advances on each counter_clk while high
- count_clr  out  1  one-cycle pulse; counter loads 0:00.0
- freeze  out  1  display holds its last latched value while high
- state  out  2  current FSM state

## Operation
- Button conditioning, per button:
  - 2-flop synchronizer feeds a DB_LEN-bit shift register.
  - The debounced level db rises when all DB_LEN bits are 1 and falls when all are 0. Otherwise db holds.
  - A registered pulse p is high for exactly one cycle, on the same edge where db goes 0→1.
  - Presses shorter than about DB_LEN ticks are ignored by design.
- FSM states and encodings: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- Event priority within one cycle: clear_p > at_max > start_p > lap_p.
- IDLE:
  - start_p → RUN.
  - clear_p → stay in IDLE and pulse count_clr.
- RUN:
  - clear_p → IDLE with count_clr.
  - else at_max → DONE.
  - else start_p → PAUSE.
  - lap_p toggles freeze.
- PAUSE:
  - clear_p → IDLE with count_clr.
  - start_p → RUN.
  - lap_p sets freeze to 0.
- DONE:
  - clear_p → IDLE with count_clr.
  - start_p and lap_p are ignored.
- count_en = (state == RUN), decoded from the state register only.
- freeze is forced to 0 on every transition into IDLE or DONE, so the final time is always shown.
- Simultaneous events:
  - start_p and clear_p in the same cycle: clear wins; start is dropped, not queued.
  - at_max and start_p in RUN: DONE.

## Timing
- Reset (asynchronous assert): synchronizers, shift registers, db, p, freeze and count_clr clear to 0; state = IDLE; count_en = 0.
- Reset deassertion is used as-is, with no internal synchronizer.
- A button held through reset deasserting produces one pulse after the normal latency. This is accepted behaviour.
- Latency:
  - The first counter_clk edge that samples a button high is edge 1.
  - p is high after edge 3+DB_LEN.
  - state, count_en, count_clr and freeze update at edge 4+DB_LEN (edge 6 with DB_LEN=2).
- count_clr is registered, high for exactly one cycle, coincident with the first cycle of IDLE.
- at_max is sampled synchronously. DONE is entered on the edge after at_max is seen high in RUN, so count_en drops in the same cycle the counter would wrap.
- A held button yields one pulse only. Release requires DB_LEN consecutive low samples before another press is recognised.
- Reset asserted mid-RUN: all outputs drop immediately, asynchronously.

## Structure
- Package stopwatch_pkg holds:
  - the state encodings (IDLE, RUN, PAUSE, DONE, 2 bits)
  - the default DB_LEN
- The package is shared with the time counter and display stages.
- Sub-module btn_conditioner contains the synchronizer, debounce shift register, db and one-pulse. It is parameterised by DB_LEN and instantiated three times.
- The top level holds the FSM, the freeze register and the count_clr register only.

## Test plan
- Reset, then hold start_btn from edge 1 → state=01 and count_en=1 after edge 6; no second transition while held for 50 cycles.
- Start_btn high for 1 cycle only → no state change, count_en stays 0.
- In RUN: press lap, then press lap again → freeze 0→1 six edges after the first press, 1→0 after the second; count_en=1 throughout.
- In RUN, drive at_max=1 → state=11 and count_en=0 next edge; freeze forced 0; a later start press leaves state=11; a clear press gives state=00 with count_clr high for one cycle.
- Assert start_btn and clear_btn together in PAUSE → state=00, count_clr one-cycle pulse, no RUN entry.
- Assert reset mid-RUN with freeze=1 → count_en, freeze and count_clr go 0 and state goes 00 without waiting for a clock edge.
